exec_stage_mc: RTL and testbench
================================

EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (power of two, 8..64).
REQ-002 SHALL have parameter OPT_WIDTH, default 4, width of alu_op.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  issue request from ID.
REQ-006 SHALL have port in_ready  output  1  unit can accept an issue this cycle.
REQ-007 SHALL have port alu_op  input  OPT_WIDTH  operation code.
REQ-008 SHALL have ports id_a, id_b  input  DATA_WIDTH  operands from ID.
REQ-009 SHALL have ports fwd_mem, fwd_wb  input  DATA_WIDTH  forwarded MEM-read and WB values.
REQ-010 SHALL have ports sel_a, sel_b  input  2  operand source: 00 ID, 01 MEM, 10 WB, 11 ID.
REQ-011 SHALL have port flush  input  1  discard in-flight operation.
REQ-012 SHALL have port out_valid  output  1  result held valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port result  output  DATA_WIDTH  registered result.
REQ-015 SHALL have port op_err  output  1  unknown opcode flag, qualified by out_valid.

Function
REQ-016 Opcodes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed A<B), 5 SLTU, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low half), 11 DIVU, 12 REMU; 13-15 unknown.
REQ-017 Operand mux (sel_a/sel_b) SHALL be sampled only on the accept edge (in_valid && in_ready); operands are then held internally.
REQ-018 FSM SHALL have states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, else 0.
REQ-020 Ops 0-9 and unknown: accept -> DONE next edge; out_valid high in the cycle after accept.
REQ-021 Ops 10-12: accept -> BUSY; one iteration per cycle for DATA_WIDTH cycles (shift-add multiply, restoring divide); out_valid high exactly DATA_WIDTH+1 cycles after accept edge.
REQ-022 DONE: result/op_err/out_valid held stable until out_ready=1; on that edge go IDLE, or directly to new op if simultaneously accepted (back-to-back, no bubble).
REQ-023 Shift amount SHALL be id_b[log2(DATA_WIDTH)-1:0]; upper bits ignored.
REQ-024 ADD/SUB/MUL SHALL wrap modulo 2^DATA_WIDTH; no overflow flag.
REQ-025 DIVU by zero SHALL give all-ones; REMU by zero SHALL give dividend A.
REQ-026 Unknown opcode SHALL give result 0, op_err=1; op_err=0 for all valid opcodes.
REQ-027 flush SHALL, on its edge, force IDLE and out_valid=0 from any state; flush has priority over a same-cycle accept (request dropped).
REQ-028 in_valid while in_ready=0 SHALL be ignored (upstream holds request).

Reset
REQ-029 rst_n=0 SHALL immediately (no clock) force state IDLE, out_valid=0, result=0, op_err=0, iteration counter=0.
REQ-030 in_ready SHALL be 1 while in reset and the first cycle after release.
REQ-031 Reset asserted mid-BUSY SHALL abandon the operation; no result is ever presented.

Verification
REQ-032 ADD, sel_a=01 fwd_mem=0x10, id_b=0x5, out_ready=1 -> next cycle out_valid=1, result=0x15.
REQ-033 SLT id_a=0xFFFFFFFF, id_b=1 -> result 1; SLTU same operands -> result 0.
REQ-034 MUL 0x0001_0003 x 0x0002_0000 -> in_ready=0 for 32 cycles, out_valid at cycle 33, result 0x0006_0000.
REQ-035 DIVU 100/0 -> 0xFFFFFFFF; REMU 100/7 -> 2; out_ready=0 for 5 cycles -> result held, in_ready=0.
REQ-036 DIVU issued, flush at BUSY cycle 10 -> out_valid never asserts, in_ready=1 next cycle; new ADD 1+1 -> 2.
REQ-037 rst_n low at BUSY cycle 5 of MUL -> out_valid=0 immediately; alu_op=14 after release -> result 0, op_err=1.

Source files
------------

// File: rtl/exec_stage_mc.sv
// exec_stage_mc -- execute stage with single-cycle ALU ops and iterative
// multiply / unsigned divide.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  issue handshake from ID
//   alu_op              operation code (13-15 are unknown and flag op_err)
//   id_a, id_b          operands from ID
//   fwd_mem, fwd_wb     forwarded MEM / WB values
//   sel_a, sel_b        operand source: 00 ID, 01 MEM, 10 WB, 11 ID
//   flush               drop whatever is in flight (wins over an accept)
//   out_valid, out_ready result handshake to downstream
//   result, op_err      registered result and unknown-opcode flag
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until that edge;
// the consumer may raise or drop ready freely. in_ready is combinational on
// out_ready so a result can leave and a new op enter on the same edge.
module exec_stage_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int OPT_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [OPT_WIDTH-1:0]  alu_op,
   input  logic [DATA_WIDTH-1:0] id_a,
   input  logic [DATA_WIDTH-1:0] id_b,
   input  logic [DATA_WIDTH-1:0] fwd_mem,
   input  logic [DATA_WIDTH-1:0] fwd_wb,
   input  logic [1:0]            sel_a,
   input  logic [1:0]            sel_b,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  op_err
);

   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [OPT_WIDTH-1:0] OP_AND  = OPT_WIDTH'(0);
   localparam logic [OPT_WIDTH-1:0] OP_OR   = OPT_WIDTH'(1);
   localparam logic [OPT_WIDTH-1:0] OP_ADD  = OPT_WIDTH'(2);
   localparam logic [OPT_WIDTH-1:0] OP_SUB  = OPT_WIDTH'(3);
   localparam logic [OPT_WIDTH-1:0] OP_SLT  = OPT_WIDTH'(4);
   localparam logic [OPT_WIDTH-1:0] OP_SLTU = OPT_WIDTH'(5);
   localparam logic [OPT_WIDTH-1:0] OP_XOR  = OPT_WIDTH'(6);
   localparam logic [OPT_WIDTH-1:0] OP_SLL  = OPT_WIDTH'(7);
   localparam logic [OPT_WIDTH-1:0] OP_SRL  = OPT_WIDTH'(8);
   localparam logic [OPT_WIDTH-1:0] OP_SRA  = OPT_WIDTH'(9);
   localparam logic [OPT_WIDTH-1:0] OP_MUL  = OPT_WIDTH'(10);
   localparam logic [OPT_WIDTH-1:0] OP_DIVU = OPT_WIDTH'(11);
   localparam logic [OPT_WIDTH-1:0] OP_REMU = OPT_WIDTH'(12);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state_q, state_d;
   logic                  accept;
   logic                  is_multi;
   logic                  last_iter;
   logic [DATA_WIDTH-1:0] a_mux, b_mux;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_unknown;
   logic [SHW-1:0]        shamt;

   // Iterative datapath. MUL: opa = shifting multiplicand, opb = shifting
   // multiplier, acc = partial product. DIVU/REMU: opa = dividend shifting
   // out / quotient shifting in, opb = divisor, acc = partial remainder.
   logic [DATA_WIDTH-1:0] opa, opb, acc;
   logic                  is_mul, is_rem;
   logic [SHW-1:0]        cnt;
   logic [DATA_WIDTH-1:0] mul_nx;
   logic [DATA_WIDTH:0]   div_shift;
   logic                  div_ge;
   logic [DATA_WIDTH-1:0] div_diff, rem_nx, quo_nx, iter_res;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign out_valid = (state_q == DONE);
   assign is_multi  = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
   assign last_iter = (cnt == SHW'(DATA_WIDTH - 1));

   always_comb begin
      case (sel_a)
         2'b01:   a_mux = fwd_mem;
         2'b10:   a_mux = fwd_wb;
         default: a_mux = id_a;
      endcase
      case (sel_b)
         2'b01:   b_mux = fwd_mem;
         2'b10:   b_mux = fwd_wb;
         default: b_mux = id_b;
      endcase
   end

   assign shamt = b_mux[SHW-1:0];

   always_comb begin
      alu_res     = '0;
      alu_unknown = 1'b0;
      case (alu_op)
         OP_AND:  alu_res = a_mux & b_mux;
         OP_OR:   alu_res = a_mux | b_mux;
         OP_ADD:  alu_res = a_mux + b_mux;
         OP_SUB:  alu_res = a_mux - b_mux;
         OP_SLT:  alu_res[0] = $signed(a_mux) < $signed(b_mux);
         OP_SLTU: alu_res[0] = a_mux < b_mux;
         OP_XOR:  alu_res = a_mux ^ b_mux;
         OP_SLL:  alu_res = a_mux << shamt;
         OP_SRL:  alu_res = a_mux >> shamt;
         OP_SRA:  alu_res = $signed(a_mux) >>> shamt;
         OP_MUL, OP_DIVU, OP_REMU: alu_res = '0;
         default: alu_unknown = 1'b1;
      endcase
   end

   // Restoring divide: a zero divisor always "fits", which yields an
   // all-ones quotient and leaves the dividend as remainder.
   assign mul_nx    = acc + (opb[0] ? opa : '0);
   assign div_shift = {acc, opa[DATA_WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opb};
   assign div_diff  = div_shift[DATA_WIDTH-1:0] - opb;
   assign rem_nx    = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
   assign quo_nx    = {opa[DATA_WIDTH-2:0], div_ge};
   assign iter_res  = is_mul ? mul_nx : (is_rem ? rem_nx : quo_nx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (accept) state_d = is_multi ? BUSY : DONE;
            BUSY: if (last_iter) state_d = DONE;
            DONE: begin
               if (accept)         state_d = is_multi ? BUSY : DONE;
               else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
         op_err <= 1'b0;
         cnt    <= '0;
         opa    <= '0;
         opb    <= '0;
         acc    <= '0;
         is_mul <= 1'b0;
         is_rem <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
         if (is_multi) begin
            opa    <= a_mux;
            opb    <= b_mux;
            acc    <= '0;
            is_mul <= (alu_op == OP_MUL);
            is_rem <= (alu_op == OP_REMU);
         end else begin
            result <= alu_res;
            op_err <= alu_unknown;
         end
      end else if (state_q == BUSY) begin
         cnt <= cnt + SHW'(1);
         if (is_mul) begin
            acc <= mul_nx;
            opa <= opa << 1;
            opb <= opb >> 1;
         end else begin
            acc <= rem_nx;
            opa <= quo_nx;
         end
         if (last_iter) begin
            result <= iter_res;
            op_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exec_stage_mc.sv
// tb_exec_stage_mc -- randomized + directed bench for exec_stage_mc.
// A behavioural model (plain arithmetic, operation latency counted in cycles)
// predicts in_ready, out_valid, result and op_err every cycle; directed
// cases pin the model with hand-computed literals.
module tb_exec_stage_mc;

   localparam int W   = 32;
   localparam int SHW = 5;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   alu_op;
   logic [W-1:0] id_a, id_b, fwd_mem, fwd_wb;
   logic [1:0]   sel_a, sel_b;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         op_err;

   exec_stage_mc #(.DATA_WIDTH(W), .OPT_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .id_a(id_a), .id_b(id_b), .fwd_mem(fwd_mem),
      .fwd_wb(fwd_wb), .sel_a(sel_a), .sel_b(sel_b), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .op_err(op_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   bit rdy_random   = 1'b0;
   bit flush_random = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- comparison helpers ----------------
   task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] idv);
      if (s == 2'b01) return fwd_mem;
      if (s == 2'b10) return fwd_wb;
      return idv;
   endfunction

   // Returns {op_err, result}.
   function automatic logic [W:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         e;
      int           sh;
      r  = '0;
      e  = 1'b0;
      sh = int'(b[SHW-1:0]);
      case (op)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a + b;
         4'd3:  r = a - b;
         4'd4:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd5:  r = {{(W-1){1'b0}}, (a < b)};
         4'd6:  r = a ^ b;
         4'd7:  r = a << sh;
         4'd8:  r = a >> sh;
         4'd9:  r = $signed(a) >>> sh;
         4'd10: r = a * b;
         4'd11: r = (b == 0) ? '1 : a / b;
         4'd12: r = (b == 0) ? a : a % b;
         default: e = 1'b1;
      endcase
      return {e, r};
   endfunction

   // ---------------- scoreboard / compare process ----------------
   logic [W:0] exp_q[$];
   logic [W:0] m_exp;
   bit         m_busy = 1'b0;
   int         m_wait = 0;
   bit         m_valid, m_ready;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         m_busy = 1'b0;
         m_wait = 0;
         exp_q.delete();
         check_b("reset in_ready", in_ready, 1'b1);
         check_b("reset out_valid", out_valid, 1'b0);
         check_w("reset result", result, '0);
         check_b("reset op_err", op_err, 1'b0);
      end else begin
         m_valid = m_busy && (m_wait == 0);
         m_ready = !m_busy || (m_valid && out_ready);
         check_b("in_ready", in_ready, m_ready);
         check_b("out_valid", out_valid, m_valid);
         if (m_valid && exp_q.size() > 0) begin
            m_exp = exp_q[0];
            check_w("result", result, m_exp[W-1:0]);
            check_b("op_err", op_err, m_exp[W]);
         end
         if (flush) begin
            m_busy = 1'b0;
            exp_q.delete();
         end else begin
            if (m_valid && out_ready) begin
               void'(exp_q.pop_front());
               m_busy = 1'b0;
            end else if (m_busy && m_wait > 0) begin
               m_wait--;
            end
            if (in_valid && m_ready) begin
               exp_q.push_back(ref_alu(alu_op, pick(sel_a, id_a), pick(sel_b, id_b)));
               m_busy = 1'b1;
               // multi-cycle ops show their result W+1 cycles after accept
               m_wait = (alu_op >= 4'd10 && alu_op <= 4'd12) ? W : 0;
            end
         end
      end
   end

   // Random out_ready / flush drivers, active only in the random phase.
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_random)   out_ready = ($urandom_range(0, 3) != 0);
      if (flush_random) flush     = ($urandom_range(0, 49) == 0);
   end

   // ---------------- driver tasks ----------------
   function automatic logic [W-1:0] rand_val();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   // Called just after a rising edge; returns just after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input logic [W-1:0] fm, input logic [W-1:0] fw);
      bit ok;
      ok = 1'b0;
      alu_op = op; id_a = a; id_b = b; sel_a = sa; sel_b = sb;
      fwd_mem = fm; fwd_wb = fw; in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            acc_cyc = cyc;
            break;
         end
      end
      check_b("issue accepted in time", ok, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // scramble inputs so held operands are really held
      alu_op = 4'($urandom_range(0, 15)); id_a = $urandom(); id_b = $urandom();
      fwd_mem = $urandom(); fwd_wb = $urandom();
      sel_a = 2'($urandom_range(0, 3)); sel_b = 2'($urandom_range(0, 3));
   endtask

   // Waits for out_valid; lat = edges from accept cycle to valid cycle,
   // low = cycles with in_ready=0 seen before valid.
   task automatic wait_valid(output int lat, output int low);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      low  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            lat  = cyc - acc_cyc;
            break;
         end
         if (!in_ready) low++;
      end
      check_b("out_valid arrives", seen, 1'b1);
   endtask

   task automatic run_op(input string name, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [W-1:0] fm, input logic [W-1:0] fw,
                         input logic [W-1:0] exp_res, input logic exp_err, input int exp_lat);
      int lat, low;
      issue(op, a, b, sa, sb, fm, fw);
      wait_valid(lat, low);
      check_w({name, " result"}, result, exp_res);
      check_b({name, " op_err"}, op_err, exp_err);
      check_i({name, " latency"}, lat, exp_lat);
      check_i({name, " in_ready low cycles"}, low, exp_lat - 1);
      @(posedge clk);
      #1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2ms;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int         lat, low, nv;
      logic [3:0] op;
      logic [1:0] sa, sb;

      rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; id_a = '0; id_b = '0;
      fwd_mem = '0; fwd_wb = '0; sel_a = '0; sel_b = '0; flush = 1'b0;
      out_ready = 1'b1;
      #2;
      check_b("por in_ready", in_ready, 1'b1);
      check_b("por out_valid", out_valid, 1'b0);
      check_w("por result", result, '0);
      check_b("por op_err", op_err, 1'b0);
      #15;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // directed single-cycle and multi-cycle cases
      run_op("add fwd_mem", 4'd2, 32'h0, 32'h5, 2'b01, 2'b00, 32'h10, 32'h0, 32'h15, 1'b0, 1);
      run_op("slt", 4'd4, 32'hFFFF_FFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h1, 1'b0, 1);
      run_op("sltu", 4'd5, 32'hFFFF_FFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1);
      run_op("sub wrap", 4'd3, 32'h0, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1);
      run_op("sra masked", 4'd9, 32'h8000_0000, 32'h24, 2'b00, 2'b00, 32'h0, 32'h0, 32'hF800_0000, 1'b0, 1);
      run_op("add fwd_wb", 4'd2, 32'h7, 32'h0, 2'b00, 2'b10, 32'h0, 32'h20, 32'h27, 1'b0, 1);
      run_op("sel 11 is id", 4'd6, 32'hF0F0, 32'h0FF0, 2'b11, 2'b11, 32'h1, 32'h2, 32'hFF00, 1'b0, 1);
      run_op("mul", 4'd10, 32'h0001_0003, 32'h0002_0000, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0006_0000, 1'b0, 33);
      run_op("divu by 0", 4'd11, 32'd100, 32'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 33);
      run_op("remu by 0", 4'd12, 32'd100, 32'd0, 2'b00, 2'b00, 32'h0, 32'h0, 32'd100, 1'b0, 33);
      run_op("divu 100/7", 4'd11, 32'd100, 32'd7, 2'b00, 2'b00, 32'h0, 32'h0, 32'd14, 1'b0, 33);

      // REMU with downstream stalled: result must hold
      out_ready = 1'b0;
      issue(4'd12, 32'd100, 32'd7, 2'b00, 2'b00, 32'h0, 32'h0);
      wait_valid(lat, low);
      check_w("remu 100/7 result", result, 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_w("stall hold result", result, 32'd2);
         check_b("stall hold out_valid", out_valid, 1'b1);
         check_b("stall in_ready", in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // flush at BUSY cycle 10 of a DIVU
      issue(4'd11, 32'd1000, 32'd3, 2'b00, 2'b00, 32'h0, 32'h0);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      check_b("flush in_ready", in_ready, 1'b1);
      check_b("flush out_valid", out_valid, 1'b0);
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      check_i("no result after flush", nv, 0);
      @(posedge clk);
      #1;
      run_op("add after flush", 4'd2, 32'h1, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h2, 1'b0, 1);

      // reset at BUSY cycle 5 of a MUL
      issue(4'd10, 32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 2'b00, 32'h0, 32'h0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_b("async reset out_valid", out_valid, 1'b0);
      check_b("async reset in_ready", in_ready, 1'b1);
      check_w("async reset result", result, '0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check_b("in_ready after release", in_ready, 1'b1);
      check_b("no result after reset", out_valid, 1'b0);
      @(posedge clk);
      #1;
      run_op("unknown op 14", 4'd14, 32'h55, 32'hAA, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1);

      // randomized phase
      rdy_random   = 1'b1;
      flush_random = 1'b1;
      for (int n = 0; n < 150; n++) begin
         op = 4'($urandom_range(0, 15));
         sa = 2'($urandom_range(0, 3));
         sb = (op >= 4'd7 && op <= 4'd9) ? 2'b00 : 2'($urandom_range(0, 3));
         issue(op, rand_val(), rand_val(), sa, sb, rand_val(), rand_val());
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_random   = 1'b0;
      flush_random = 1'b0;
      @(posedge clk);
      #2;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      check_i("drained scoreboard", exp_q.size(), 0);
      check_b("drained out_valid", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
